// File: rtl/seq_array_mult.sv
// Iterative shift-and-add WIDTH x WIDTH multiplier, STEP multiplier bits per cycle; result WIDTH/STEP edges after accept,
// held in DONE until out_ready (in_ready follows out_ready there). Define MULT_SIGNED_EN to honour sign_mode (two's complement).
module seq_array_mult #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = WIDTH / STEP;
  localparam int ACC_W = 2 * WIDTH + STEP;
  localparam int CNT_W = $clog2(N + 1);

  if (WIDTH < 2 || !(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("seq_array_mult: WIDTH must be >= 2, STEP in {1,2,4} and STEP must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   a_sh;
  logic [ACC_W-1:0]   a_ext;
  logic [WIDTH-1:0]   b_sh;
  logic [CNT_W-1:0]   count;
  logic               signed_q;
  logic               sign_in;
  logic               last;
  logic               accept;

`ifdef MULT_SIGNED_EN
  assign sign_in = sign_mode;
`else
  logic unused_sign_mode;
  assign unused_sign_mode = sign_mode;
  assign sign_in          = 1'b0;
`endif

  assign a_ext    = {{(ACC_W - WIDTH){sign_in & a[WIDTH-1]}}, a};
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (count == CNT_W'(N - 1));

  // In signed mode the final chunk holds b's MSB, whose weight is negative.
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < STEP; j++) begin
      if (b_sh[j]) begin
        if (signed_q && last && (j == STEP - 1))
          acc_nxt = acc_nxt - (a_sh << j);
        else
          acc_nxt = acc_nxt + (a_sh << j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      count     <= '0;
      signed_q  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          acc   <= acc_nxt;
          a_sh  <= a_sh << STEP;
          b_sh  <= b_sh >> STEP;
          count <= count + 1'b1;
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            product   <= acc_nxt[2*WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Accept overrides the DONE->IDLE move so back-to-back operations have no bubble.
      if (accept) begin
        state    <= BUSY;
        busy     <= 1'b1;
        acc      <= '0;
        a_sh     <= a_ext;
        b_sh     <= b;
        count    <= '0;
        signed_q <= sign_in;
      end
    end
  end

endmodule
